serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder: accepts two WIDTH-bit operands over a valid/ready handshake and adds them LSB-first, one bit per clock.
- Each bit is summed in a single-bit full-adder cell; a carry flip-flop holds the carry between bits.
- Sits directly downstream of the team's combinational half/full-adder cells. Trades area for latency in the arithmetic datapath.
- Result is held with carry-out until a consumer accepts it.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- Clock and reset (already decided): one clock, clk; reset rst_n, asynchronous, active-low.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- carry  output  1  carry-out of MSB.

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (async, any state, including mid-RUN): state=IDLE, sum=0, carry=0, out_valid=0, in_ready=1.
  - Operand shift registers, bit counter and carry flop also clear to 0.
  - In-flight operation is discarded; no partial result is presented.
- IDLE -> RUN on an edge with in_valid=1.
  - Load a and b into shift registers, clear the carry flop, set bit counter to 0.
- RUN, each edge:
  - Cell computes s = a_sr[0] ^ b_sr[0] ^ c and c' = majority(a_sr[0], b_sr[0], c).
  - s shifts into sum from the MSB side; sum shifts right; a_sr and b_sr shift right; carry flop <= c'; counter++.
  - When the counter reaches WIDTH-1, that edge processes the final bit and moves to DONE.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- DONE:
  - sum and carry hold stable while out_valid=1 and out_ready=0 (backpressure of any length).
  - On an edge with out_ready=1, go to IDLE; sum/carry keep their values, out_valid drops.
- Handshake rules:
  - in_valid while in RUN or DONE is ignored (in_ready=0). Upstream must hold operands until accepted.
  - No back-to-back overlap: after a result is accepted in DONE, the next accept can happen no earlier than the following edge in IDLE.
  - in_ready is combinational from state only, never from in_valid.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - {carry, sum} equals a+b exactly (WIDTH+1 bits).
- out_ready during IDLE/RUN has no effect.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled on the accept edge.
  - When sub=1: the B register loads ~b and the carry flop initialises to 1, so sum = a-b modulo 2^WIDTH.
  - carry=1 means no borrow (a>=b); carry=0 means borrow.
  - Extra output port borrow = ~carry, valid with out_valid.
- Undefined:
  - No sub or borrow ports; the carry flop always initialises to 0.
  - Logic identical to sub=0.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum (IDLE, RUN, DONE) with encoding 2'b00/01/10; 2'b11 recovers to IDLE.
  - Counter width constant CNT_W = $clog2(WIDTH).
- One sub-module: full_adder_bit. Pure combinational cell (a, b, cin -> s, cout), built from two half-adder stages plus an OR.

Test Plan:
- WIDTH=4, a=0101, b=0011, out_ready=1 -> out_valid rises 4 edges after accept; sum=1000, carry=0.
- WIDTH=4, a=1111, b=0001 -> sum=0000, carry=1. Also a=1111, b=1111 -> sum=1110, carry=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> sum/carry/out_valid stable; in_ready=0 throughout.
  - Then out_ready=1 for one cycle -> IDLE, in_ready=1.
- Operands change and in_valid pulses during RUN -> ignored; result matches the originally accepted operands.
- Deassert rst_n after 2 of 4 RUN cycles -> immediately out_valid=0, sum=0, carry=0, in_ready=1.
  - A fresh a=0010, b=0010 then yields sum=0100.
- With SERIAL_ADDER_SUB_EN and sub=1:
  - a=0011, b=0101 -> sum=1110, carry=0, borrow=1.
  - a=0101, b=0011 -> sum=0010, borrow=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// counter sizing helper.
package serial_adder_pkg;

    // FSM states; the unused code 2'b11 is decoded back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Legal operand width range.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Bit-counter width: CNT_W = $clog2(WIDTH), never below one bit.
    function automatic int cnt_width(input int width);
        if (width <= 1) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_bit.sv
// Single-bit full adder built from two half-adder stages plus an OR for
// the carry. Purely combinational.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha1_s;
    logic ha1_c;
    logic ha2_c;

    // First half adder combines the two operand bits.
    assign ha1_s = a ^ b;
    assign ha1_c = a & b;

    // Second half adder folds in the incoming carry.
    assign s     = ha1_s ^ cin;
    assign ha2_c = ha1_s & cin;

    // A carry out is produced by either half-adder stage.
    assign cout  = ha1_c | ha2_c;

endmodule : full_adder_bit

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are accepted over a valid/ready
// handshake, summed LSB-first one bit per clock through a single full-adder
// cell, and the result {carry, sum} is held until the consumer accepts it.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input (a - b)
// and a 'borrow' output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_SUB_EN
    ,
    output logic             borrow
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t            state_r;
    logic [WIDTH-1:0]  a_sr_r;
    logic [WIDTH-1:0]  b_sr_r;
    logic [WIDTH-1:0]  sum_r;
    logic              carry_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [WIDTH-1:0]  b_load_s;
    logic              c_init_s;
    logic              fa_s_s;
    logic              fa_cout_s;

    // Operand-B load value and initial carry; subtraction is a + ~b + 1.
    always_comb begin
        b_load_s = b;
        c_init_s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load_s = ~b;
            c_init_s = 1'b1;
        end else begin
            b_load_s = b;
            c_init_s = 1'b0;
        end
`endif
    end

    // The one arithmetic cell, fed from the operand LSBs and the carry flop.
    full_adder_bit u_fa (
        .a    (a_sr_r[0]),
        .b    (b_sr_r[0]),
        .cin  (carry_r),
        .s    (fa_s_s),
        .cout (fa_cout_s)
    );

    // Control FSM and serial datapath: load, shift one bit per clock, hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_sr_r  <= {WIDTH{1'b0}};
            b_sr_r  <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b_load_s;
                        carry_r <= c_init_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Sum bits enter at the MSB so the LSB lands at bit 0
                    // after WIDTH shifts.
                    sum_r   <= {fa_s_s, sum_r[WIDTH-1:1]};
                    a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Result holds under backpressure; acceptance returns
                    // to idle with sum/carry left in place.
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags are decoded from the state register only.
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign sum       = sum_r;
    assign carry     = carry_r;
`ifdef SERIAL_ADDER_SUB_EN
    assign borrow    = ~carry_r;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4): directed cases with
// hand-computed results, randomized operations against an arithmetic
// reference model, backpressure, ignored input during RUN and mid-run reset.
module tb_serial_adder;

    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
`ifdef SERIAL_ADDER_SUB_EN
    logic         borrow;
`endif

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .borrow    (borrow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 busy, 2 result presented.
    int       m_phase;
    int       m_left;
    int       m_sum;
    int       m_carry;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
            m_sum   = 0;
            m_carry = 0;
        end else begin
            if (m_phase == 0) begin
                if (in_valid === 1'b1) begin
                    m_phase = 1;
                    m_left  = W;
`ifdef SERIAL_ADDER_SUB_EN
                    if (sub) begin
                        m_sum   = (int'(a) - int'(b)) & MASK;
                        m_carry = (a >= b) ? 1 : 0;
                    end else begin
                        m_sum   = (int'(a) + int'(b)) & MASK;
                        m_carry = ((int'(a) + int'(b)) > MASK) ? 1 : 0;
                    end
`else
                    m_sum   = (int'(a) + int'(b)) & MASK;
                    m_carry = ((int'(a) + int'(b)) > MASK) ? 1 : 0;
`endif
                end
            end else if (m_phase == 1) begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = 2;
            end else begin
                if (out_ready === 1'b1) m_phase = 0;
            end
        end
    end

    // Compare process: handshake flags always, result whenever it is visible.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            if (m_phase != 1) begin
                chk("sum", 32'(sum), 32'(m_sum));
                chk("carry", 32'(carry), 32'(m_carry));
`ifdef SERIAL_ADDER_SUB_EN
                if (m_phase == 2) chk("borrow", 32'(borrow), 32'(m_carry == 0));
`endif
            end
        end
    end

    // One operation: accept, optionally disturb inputs during RUN, wait for
    // the result, apply backpressure, then accept the result.
    task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s,
                         input int bp, input logic noise,
                         output logic [W-1:0] rs, output logic rc);
        int lat;
        @(posedge clk); #1;
        a = aa; b = bb; sub = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;               // accept edge
        in_valid = 1'b0;
        lat = 0;
        rs = '0; rc = 1'b0;
        while (out_valid !== 1'b1 && lat < 50) begin
            if (noise) begin
                a = W'($urandom); b = W'($urandom);
                in_valid = 1'($urandom); out_ready = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
            in_valid = 1'b0; out_ready = 1'b0;
        end
        chk("latency", 32'(lat), 32'(W));
        if (lat >= 50) begin
            $display("FAIL timeout: got no out_valid, expected it after %0d edges", W);
        end else begin
            rs = sum; rc = carry;
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                chk("bp_valid", 32'(out_valid), 32'd1);
                chk("bp_ready", 32'(in_ready), 32'd0);
                chk("bp_sum", 32'(sum), 32'(rs));
                chk("bp_carry", 32'(carry), 32'(rc));
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("post_in_ready", 32'(in_ready), 32'd1);
            chk("post_out_valid", 32'(out_valid), 32'd0);
        end
    endtask

    logic [W-1:0] rs;
    logic         rc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Hand-computed results pin the model.
        do_op(4'b0101, 4'b0011, 1'b0, 0, 1'b0, rs, rc);
        chk("d1_sum", 32'(rs), 32'(4'b1000)); chk("d1_carry", 32'(rc), 32'd0);
        do_op(4'b1111, 4'b0001, 1'b0, 0, 1'b0, rs, rc);
        chk("d2_sum", 32'(rs), 32'(4'b0000)); chk("d2_carry", 32'(rc), 32'd1);
        do_op(4'b1111, 4'b1111, 1'b0, 10, 1'b0, rs, rc);
        chk("d3_sum", 32'(rs), 32'(4'b1110)); chk("d3_carry", 32'(rc), 32'd1);
        do_op(4'b0110, 4'b0111, 1'b0, 2, 1'b1, rs, rc);
        chk("d4_sum", 32'(rs), 32'(4'b1101)); chk("d4_carry", 32'(rc), 32'd0);
`ifdef SERIAL_ADDER_SUB_EN
        do_op(4'b0011, 4'b0101, 1'b1, 0, 1'b0, rs, rc);
        chk("s1_sum", 32'(rs), 32'(4'b1110)); chk("s1_carry", 32'(rc), 32'd0);
        chk("s1_borrow", 32'(borrow), 32'd1);
        do_op(4'b0101, 4'b0011, 1'b1, 0, 1'b0, rs, rc);
        chk("s2_sum", 32'(rs), 32'(4'b0010)); chk("s2_borrow", 32'(~rc), 32'd0);
`endif

        // Reset after two of four RUN cycles.
        @(posedge clk); #1;
        a = 4'b0101; b = 4'b0011; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_carry", 32'(carry), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        do_op(4'b0010, 4'b0010, 1'b0, 1, 1'b0, rs, rc);
        chk("after_rst_sum", 32'(rs), 32'(4'b0100)); chk("after_rst_carry", 32'(rc), 32'd0);

        // Randomized operations against the model.
        for (int n = 0; n < 40; n++) begin
`ifdef SERIAL_ADDER_SUB_EN
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom), rs, rc);
`else
            do_op(W'($urandom), W'($urandom), 1'b0, int'($urandom_range(0, 3)),
                  1'($urandom), rs, rc);
`endif
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder
